// File: rtl/regfile_reader_pkg.sv
// Shared types and defaults for the register-file read-out engine.
// Holds the FSM state encoding and the window-length clamp.
package regfile_reader_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NREGS  = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPT,
        SEND,
        FIN
    } rdr_state_e;

    function automatic int unsigned clamp_count(
        input int unsigned cnt,
        input int unsigned nregs
    );
        return (cnt > nregs) ? nregs : cnt;
    endfunction

endpackage

// File: rtl/regfile_reader_ctrl.sv
// Read-out sequencer: walks the address window, paces the read port
// and the stream handshake, and flags the final word.
module regfile_reader_ctrl
    import regfile_reader_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREGS  = RF_NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    input  logic              out_ready,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              out_valid_o,
    output logic              capt_o,
    output logic              last_o,
    output logic              clr_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int REM_W = ADDR_W + 1;

    rdr_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [REM_W-1:0]  rem_q;
    logic              rd_en_q;
    logic              valid_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_nxt;

    assign addr_nxt = (addr_q == ADDR_W'(NREGS - 1)) ? '0 : addr_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            // abort outranks both start and a pending handshake
            if (abort) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start && count == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else if (start) begin
                            addr_q  <= first_addr;
                            rem_q   <= REM_W'(clamp_count(32'(count), NREGS));
                            rd_en_q <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                    ISSUE: state_q <= CAPT;
                    CAPT: begin
                        valid_q <= 1'b1;
                        state_q <= SEND;
                    end
                    SEND: begin
                        if (out_ready && rem_q > REM_W'(1)) begin
                            valid_q <= 1'b0;
                            rem_q   <= rem_q - 1'b1;
                            addr_q  <= addr_nxt;
                            rd_en_q <= 1'b1;
                            state_q <= ISSUE;
                        end else if (out_ready) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                    FIN:     state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rd_en_o     = rd_en_q;
    assign addr_o      = addr_q;
    assign out_valid_o = valid_q;
    assign capt_o      = (state_q == CAPT);
    assign last_o      = (rem_q == REM_W'(1));
    assign clr_o       = abort && (state_q != IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

endmodule

// File: rtl/regfile_reader.sv
// Streams a window of register-file words out over valid/ready.
// The sequencer drives the read port; this level captures each word.
module regfile_reader
    import regfile_reader_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREGS  = RF_NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    logic              capt;
    logic              last;
    logic              clr;
    logic [DATA_W-1:0] data_d, data_q;
    logic [ADDR_W-1:0] oaddr_d, oaddr_q;
    logic              last_d, last_q;

    regfile_reader_ctrl #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .first_addr  (first_addr),
        .count       (count),
        .abort       (abort),
        .out_ready   (out_ready),
        .rd_en_o     (rd_en),
        .addr_o      (rd_addr),
        .out_valid_o (out_valid),
        .capt_o      (capt),
        .last_o      (last),
        .clr_o       (clr),
        .busy_o      (busy),
        .done_o      (done)
    );

    always_comb begin
        data_d  = data_q;
        oaddr_d = oaddr_q;
        last_d  = last_q;
        if (clr) begin
            last_d = 1'b0;
        end else if (capt) begin
            data_d  = rd_data;
            oaddr_d = rd_addr;
            last_d  = last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            oaddr_q <= '0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            oaddr_q <= oaddr_d;
            last_q  <= last_d;
        end
    end

    assign out_data = data_q;
    assign out_addr = oaddr_q;
    assign out_last = last_q;

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader with a register-file model
// whose entry i holds i*0x11111111.
module tb_regfile_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  first_addr = '0;
    logic [5:0]  count = '0;
    logic        abort = 1'b0;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        done;

    regfile_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .count      (count),
        .abort      (abort),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [32];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] q_data [$];
    logic [4:0]  q_addr [$];
    logic        q_last [$];
    int rd_cnt = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int valid_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (rd_en) rd_cnt++;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (out_valid) valid_cnt++;
            if (out_valid && out_ready && !abort) begin
                q_data.push_back(out_data);
                q_addr.push_back(out_addr);
                q_last.push_back(out_last);
            end
        end
    end

    task automatic clear_mon();
        q_data.delete();
        q_addr.delete();
        q_last.delete();
        rd_cnt = 0;
        done_cnt = 0;
        busy_cnt = 0;
        valid_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int f, input int c);
        start = 1'b1;
        first_addr = 5'(f);
        count = 6'(c);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            tick();
            cyc++;
        end
        check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_words(input int f, input int n);
        logic [4:0]  a;
        logic [31:0] d;
        check("word_count", q_addr.size(), n);
        for (int i = 0; i < n && i < q_addr.size(); i++) begin
            a = 5'((f + i) % 32);
            d = 32'h11111111 * a;
            check($sformatf("addr[%0d]", i), 32'(q_addr[i]), 32'(a));
            check($sformatf("data[%0d]", i), q_data[i], d);
            check($sformatf("last[%0d]", i), 32'(q_last[i]),
                  32'(i == n - 1));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"}, 32'(rd_en), 0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_oaddr"}, 32'(out_addr), 0);
        check({tag, "_last"}, 32'(out_last), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 32; i++) mem[i] = 32'h11111111 * 32'(i);

        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b1;
        tick();

        // 1: full file, ready tied high
        clear_mon();
        launch(0, 32);
        wait_done(200, cyc);
        check("t1_done_cycle", cyc, 96);
        tick();
        check("t1_busy_after", 32'(busy), 0);
        check("t1_busy_cycles", busy_cnt, 97);
        check("t1_rd_en_cnt", rd_cnt, 32);
        check("t1_done_cnt", done_cnt, 1);
        check_words(0, 32);

        // 2: wrapping window, first-valid latency
        clear_mon();
        launch(30, 4);
        check("t2_valid_c1", 32'(out_valid), 0);
        tick();
        check("t2_valid_c2", 32'(out_valid), 0);
        tick();
        check("t2_valid_c3", 32'(out_valid), 1);
        wait_done(50, cyc);
        tick();
        check("t2_rd_en_cnt", rd_cnt, 4);
        check("t2_done_cnt", done_cnt, 1);
        check_words(30, 4);

        // 3: empty window
        clear_mon();
        launch(7, 0);
        check("t3_done", 32'(done), 1);
        check("t3_busy", 32'(busy), 1);
        tick();
        check("t3_done_after", 32'(done), 0);
        check("t3_busy_after", 32'(busy), 0);
        tick();
        check("t3_rd_en_cnt", rd_cnt, 0);
        check("t3_valid_cnt", valid_cnt, 0);
        check("t3_done_cnt", done_cnt, 1);

        // 4: oversize count clamps to the file size
        clear_mon();
        launch(5, 40);
        wait_done(200, cyc);
        tick();
        check("t4_rd_en_cnt", rd_cnt, 32);
        check("t4_done_cnt", done_cnt, 1);
        check_words(5, 32);

        // 5: back-pressure holds the word; start is ignored
        clear_mon();
        out_ready = 1'b0;
        launch(10, 3);
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            first_addr = 5'd0;
            count = 6'd1;
            tick();
        end
        start = 1'b0;
        check("t5_valid", 32'(out_valid), 1);
        check("t5_data", out_data, 32'hAAAAAAAA);
        check("t5_addr", 32'(out_addr), 10);
        check("t5_last", 32'(out_last), 0);
        check("t5_rd_en_cnt", rd_cnt, 1);
        out_ready = 1'b1;
        wait_done(50, cyc);
        tick();
        check("t5_done_cnt", done_cnt, 1);
        check_words(10, 3);

        // 6: abort on the second word, then reset mid-run
        clear_mon();
        launch(0, 8);
        cyc = 0;
        while (!(out_valid && q_addr.size() == 1) && cyc < 20) begin
            tick();
            cyc++;
        end
        check("t6_second_word", 32'(out_addr), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_abort_valid", 32'(out_valid), 0);
        check("t6_abort_last", 32'(out_last), 0);
        check("t6_abort_busy", 32'(busy), 0);
        tick();
        check("t6_accepted", q_addr.size(), 1);
        launch(3, 8);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        tick();
        tick();
        check("t6_rst_busy", 32'(busy), 0);
        rst = 1'b1;
        tick();
        tick();
        check("t6_idle_busy", 32'(busy), 0);
        check("t6_done_cnt", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
